byte_data_memory: RTL and testbench

- Parametrised, byte-addressable data memory for the ARM pipeline MEM stage.
- Successor to the fixed 32-bit instruction/data store: configurable width and depth, selectable endianness, and sub-word byte/half/word accesses with sign/zero extension.
- Adds a valid/ready request channel, a registered response channel with backpressure, and range-error reporting.
- Unaligned accesses are legal within range.

---
 rtl/byte_data_memory.sv | 162 ++++++++++++++++
 tb/tb_byte_data_memory.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_data_memory.sv
// Byte-addressable data memory for the MEM stage: sized sub-word loads and stores,
// selectable endianness, a valid/ready request channel and a registered response.
module byte_data_memory #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_WIDTH  = 32,
    parameter int BIG_ENDIAN  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int MEM_AW = $clog2(DEPTH_BYTES);
    localparam int LANE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH_BYTES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [7:0]              r_mem [DEPTH_BYTES];
    logic                    r_req_ready;
    logic                    r_rsp_valid;
    logic                    r_rsp_error;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;

    logic [3:0]              w_nbytes;
    logic [ADDR_WIDTH:0]     w_end;
    logic                    w_legal;
    logic                    w_accept;
    logic                    w_rsp_done;
    logic [MEM_AW-1:0]       w_base;
    logic [7:0]              w_lane_b  [NBYTES];
    logic [7:0]              w_wdata_b [NBYTES];
    logic [LANE_W-1:0]       w_src     [NBYTES];
    logic [LANE_W-1:0]       w_msb_lane;
    logic                    w_fill;
    logic [DATA_WIDTH-1:0]   w_load_data;

    // The end address is one bit wider than the request so it cannot wrap past zero.
    assign w_nbytes   = 4'd1 << req_size;
    assign w_end      = {1'b0, req_addr} + (ADDR_WIDTH + 1)'(w_nbytes);
    assign w_legal    = (int'(w_nbytes) <= NBYTES) && (w_end <= DEPTH_L);
    assign w_base     = req_addr[MEM_AW-1:0];
    assign w_accept   = req_valid & r_req_ready;
    assign w_rsp_done = r_rsp_valid & rsp_ready;

    // Gather the addressed bytes and the lane mapping; the mapping is its own inverse.
    always_comb begin
        for (int i = 0; i < NBYTES; i++) begin
            w_wdata_b[i] = req_wdata[8*i +: 8];
            w_lane_b[i]  = r_mem[w_base + MEM_AW'(i)];
            if (BIG_ENDIAN != 0) begin
                w_src[i] = LANE_W'(int'(w_nbytes) - 1 - i);
            end else begin
                w_src[i] = LANE_W'(i);
            end
        end
    end

    // Assemble the load result into the low 8N bits and extend above them.
    always_comb begin
        w_load_data = '0;
        if (BIG_ENDIAN != 0) begin
            w_msb_lane = '0;
        end else begin
            w_msb_lane = LANE_W'(int'(w_nbytes) - 1);
        end
        w_fill = req_signed & w_lane_b[w_msb_lane][7];
        for (int p = 0; p < NBYTES; p++) begin
            if (p < int'(w_nbytes)) begin
                w_load_data[8*p +: 8] = w_lane_b[w_src[p]];
            end else begin
                w_load_data[8*p +: 8] = {8{w_fill}};
            end
        end
    end

    // Store commits at the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst && w_accept && req_write && w_legal) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (i < int'(w_nbytes)) begin
                    r_mem[w_base + MEM_AW'(i)] <= w_wdata_b[w_src[i]];
                end
            end
        end
    end

    // Next-state logic for the request/response handshake.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RESP: begin
                if (w_rsp_done) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_RESP;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered handshake and response outputs; held stable while in RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_req_ready <= (w_next_state == S_IDLE);
            if (w_accept) begin
                r_rsp_valid <= 1'b1;
                r_rsp_error <= ~w_legal;
                r_rsp_rdata <= (req_write || !w_legal) ? '0 : w_load_data;
            end else if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
                r_rsp_error <= 1'b0;
                r_rsp_rdata <= '0;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_error = r_rsp_error;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_byte_data_memory.sv
// Directed bench for byte_data_memory: a big-endian and a little-endian instance,
// expected responses queued at request time and checked when the response appears.
module tb_byte_data_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [1:0]  req_size   [2];
    logic        req_signed [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_error  [2];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    byte_data_memory #(.DATA_WIDTH(32), .DEPTH_BYTES(1024), .ADDR_WIDTH(32), .BIG_ENDIAN(1)) u_be (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0])
    );

    byte_data_memory #(.DATA_WIDTH(32), .DEPTH_BYTES(1024), .ADDR_WIDTH(32), .BIG_ENDIAN(0)) u_le (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the request accepted and returns at the next negedge.
    task automatic send(input int d, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee);
        int   w = 0;
        exp_t e;
        while (req_ready[d] !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_wait", 64'(w < 20), 64'd1);
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_size[d]   = sz;
        req_signed[d] = sg;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
        e.rdata = er;
        e.err   = ee;
        sb.push_back(e);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_wdata[d] = 32'h0;
    endtask

    task automatic collect(input int d, input string tag);
        int   w = 0;
        exp_t e;
        while (rsp_valid[d] !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_latency"}, 64'(w), 64'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e.rdata = 32'hxxxx_xxxx;
            e.err   = 1'bx;
        end
        check({tag, "_rdata"}, 64'(rsp_rdata[d]), 64'(e.rdata));
        check({tag, "_error"}, 64'(rsp_error[d]), 64'(e.err));
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        check({tag, "_valid_clr"}, 64'(rsp_valid[d]), 64'd0);
        check({tag, "_ready_back"}, 64'(req_ready[d]), 64'd1);
    endtask

    task automatic access(input int d, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee, input string tag);
        send(d, wr, sz, sg, a, wd, er, ee);
        collect(d, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]  = 1'b0;
            req_write[d]  = 1'b0;
            req_size[d]   = 2'd0;
            req_signed[d] = 1'b0;
            req_addr[d]   = 32'h0;
            req_wdata[d]  = 32'h0;
            rsp_ready[d]  = 1'b1;
        end
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready[0]), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata[0]), 64'd0);
        check("rst_rsp_error", 64'(rsp_error[0]), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_req_ready", 64'(req_ready[0]), 64'd1);

        // Word store/load and byte load, big-endian.
        access(0, 1'b1, 2'd2, 1'b0, 32'd0, 32'h1122_3344, 32'h0, 1'b0, "st_w0");
        access(0, 1'b0, 2'd2, 1'b0, 32'd0, 32'h0, 32'h1122_3344, 1'b0, "ld_w0");
        access(0, 1'b0, 2'd0, 1'b0, 32'd0, 32'h0, 32'h0000_0011, 1'b0, "ld_b0");

        // Half store with neighbours, signed and unsigned reload.
        access(0, 1'b1, 2'd0, 1'b0, 32'd5, 32'hFFFF_FF55, 32'h0, 1'b0, "st_b5");
        access(0, 1'b1, 2'd0, 1'b0, 32'd8, 32'h0000_0088, 32'h0, 1'b0, "st_b8");
        access(0, 1'b1, 2'd1, 1'b0, 32'd6, 32'hABCD_80FF, 32'h0, 1'b0, "st_h6");
        access(0, 1'b0, 2'd1, 1'b1, 32'd6, 32'h0, 32'hFFFF_80FF, 1'b0, "ld_h6s");
        access(0, 1'b0, 2'd1, 1'b0, 32'd6, 32'h0, 32'h0000_80FF, 1'b0, "ld_h6u");
        access(0, 1'b0, 2'd0, 1'b0, 32'd5, 32'h0, 32'h0000_0055, 1'b0, "ld_b5");
        access(0, 1'b0, 2'd0, 1'b0, 32'd8, 32'h0, 32'h0000_0088, 1'b0, "ld_b8");
        access(0, 1'b0, 2'd0, 1'b0, 32'd6, 32'h0, 32'h0000_0080, 1'b0, "ld_b6");

        // Unaligned word.
        access(0, 1'b1, 2'd2, 1'b0, 32'd3, 32'hA1B2_C3D4, 32'h0, 1'b0, "st_w3");
        access(0, 1'b0, 2'd2, 1'b0, 32'd3, 32'h0, 32'hA1B2_C3D4, 1'b0, "ld_w3");
        access(0, 1'b0, 2'd0, 1'b0, 32'd4, 32'h0, 32'h0000_00B2, 1'b0, "ld_b4u");
        access(0, 1'b0, 2'd0, 1'b1, 32'd4, 32'h0, 32'hFFFF_FFB2, 1'b0, "ld_b4s");

        // Range and size errors.
        access(0, 1'b1, 2'd1, 1'b0, 32'd1022, 32'h0000_BEEF, 32'h0, 1'b0, "st_h1022");
        access(0, 1'b0, 2'd2, 1'b0, 32'd1022, 32'h0, 32'h0, 1'b1, "ld_w1022_err");
        access(0, 1'b1, 2'd2, 1'b0, 32'd1022, 32'h1234_5678, 32'h0, 1'b1, "st_w1022_err");
        access(0, 1'b0, 2'd1, 1'b0, 32'd1022, 32'h0, 32'h0000_BEEF, 1'b0, "ld_h1022");
        access(0, 1'b0, 2'd0, 1'b0, 32'd1023, 32'h0, 32'h0000_00EF, 1'b0, "ld_b1023");
        access(0, 1'b0, 2'd3, 1'b0, 32'd0, 32'h0, 32'h0, 1'b1, "ld_d_err");
        access(0, 1'b1, 2'd3, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'h0, 1'b1, "st_d_err");
        access(0, 1'b0, 2'd0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1, "ld_hiaddr_err");
        access(0, 1'b0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, "ld_wrap_err");
        access(0, 1'b0, 2'd2, 1'b0, 32'd0, 32'h0, 32'h1122_33A1, 1'b0, "ld_w0_after");

        // Backpressure: response held, a competing store must not be taken.
        access(0, 1'b1, 2'd2, 1'b0, 32'h100, 32'h0000_0000, 32'h0, 1'b0, "st_w100");
        rsp_ready[0] = 1'b0;
        send(0, 1'b0, 2'd2, 1'b0, 32'd3, 32'h0, 32'hA1B2_C3D4, 1'b0);
        for (int k = 0; k < 5; k++) begin
            req_valid[0] = 1'b1;
            req_write[0] = 1'b1;
            req_size[0]  = 2'd2;
            req_addr[0]  = 32'h100;
            req_wdata[0] = 32'hDEAD_BEEF;
            check("bp_valid", 64'(rsp_valid[0]), 64'd1);
            check("bp_rdata", 64'(rsp_rdata[0]), 64'hA1B2_C3D4);
            check("bp_ready", 64'(req_ready[0]), 64'd0);
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        collect(0, "bp_release");
        access(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0000_0000, 1'b0, "ld_w100");

        // Reset while a store response is pending.
        rsp_ready[0] = 1'b0;
        send(0, 1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFE_BABE, 32'h0, 1'b0);
        check("mid_valid_pre", 64'(rsp_valid[0]), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_valid_rst", 64'(rsp_valid[0]), 64'd0);
        check("mid_ready_rst", 64'(req_ready[0]), 64'd0);
        check("mid_rdata_rst", 64'(rsp_rdata[0]), 64'd0);
        if (sb.size() > 0) begin
            void'(sb.pop_front());
        end else begin
            check("mid_sb_entry", 64'(sb.size()), 64'd1);
        end
        rst = 1'b1;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("mid_ready_rel", 64'(req_ready[0]), 64'd1);
        access(0, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'hCAFE_BABE, 1'b0, "ld_w200");
        access(0, 1'b0, 2'd1, 1'b0, 32'd3, 32'h0, 32'h0000_A1B2, 1'b0, "ld_h3_kept");

        // Little-endian instance.
        access(1, 1'b1, 2'd2, 1'b0, 32'd0, 32'h1122_3344, 32'h0, 1'b0, "le_st_w0");
        access(1, 1'b0, 2'd0, 1'b0, 32'd0, 32'h0, 32'h0000_0044, 1'b0, "le_ld_b0");
        access(1, 1'b0, 2'd2, 1'b0, 32'd0, 32'h0, 32'h1122_3344, 1'b0, "le_ld_w0");
        access(1, 1'b0, 2'd1, 1'b1, 32'd2, 32'h0, 32'h0000_1122, 1'b0, "le_ld_h2");
        access(1, 1'b1, 2'd1, 1'b0, 32'd1, 32'h0000_80AA, 32'h0, 1'b0, "le_st_h1");
        access(1, 1'b0, 2'd1, 1'b1, 32'd1, 32'h0, 32'hFFFF_80AA, 1'b0, "le_ld_h1s");
        access(1, 1'b0, 2'd2, 1'b0, 32'd0, 32'h0, 32'h1180_AA44, 1'b0, "le_ld_w0b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
